// File: rtl/bram_dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dp_pkg
//  Description : Shared types, limits and helpers for the dual-port BRAM
//                block: FSM state encoding, legal read-latency range, and
//                the per-lane collision byte-enable mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_dp_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Port B byte lane enable after same-address collision masking:
    // any lane also written by port A is taken away from port B.
    function automatic logic masked_b_be(input logic a_be,
                                         input logic b_be,
                                         input logic same_addr);
        return b_be & ~(a_be & same_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_pipe
//  Description : Valid + data delay line of STAGES registers. Data is only
//                loaded alongside a valid bit, so the output word holds its
//                value between valid pulses. STAGES=0 is a straight wire.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                valid_i/data_i  - input beat
//                valid_o/data_o  - delayed beat
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_pipe #(
    parameter int DWIDTH = 512,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clk ^ reset;
            assign valid_o   = valid_i;
            assign data_o    = data_i;
        end else begin : g_stages
            logic [STAGES-1:0] valid_q;
            logic [DWIDTH-1:0] data_q [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= '0;
                    for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    if (valid_i) data_q[0] <= data_i;
                    for (int s = 1; s < STAGES; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
                    end
                end
            end

            assign valid_o = valid_q[STAGES-1];
            assign data_o  = data_q[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_dp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dp_pipe
//  Description : True dual-port byte-enabled block RAM with RD_LATENCY-cycle
//                reads (per-port rvalid), per-byte same-address write
//                collision resolution (port A wins) and a zero-fill
//                sequencer that runs after every reset.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                init_busy             - zero-fill running, requests ignored
//                {a,b}_addr/rd/wr      - address and request strobes
//                {a,b}_byteen/wdata    - write byte enables and data
//                {a,b}_rdata/rvalid    - read data and one-cycle valid
//  Options     : BRAM_DP_RDW_FWD_EN - reads colliding with a same-cycle
//                write return the new (merged) data instead of old data.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_dp_pipe
    import bram_dp_pkg::*;
#(
    parameter int DWIDTH     = 512,
    parameter int BEWIDTH    = DWIDTH / 8,
    parameter int AWIDTH     = 9,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               init_busy,
    input  logic [AWIDTH-1:0]  a_addr,
    input  logic               a_rd,
    input  logic               a_wr,
    input  logic [BEWIDTH-1:0] a_byteen,
    input  logic [DWIDTH-1:0]  a_wdata,
    output logic [DWIDTH-1:0]  a_rdata,
    output logic               a_rvalid,
    input  logic [AWIDTH-1:0]  b_addr,
    input  logic               b_rd,
    input  logic               b_wr,
    input  logic [BEWIDTH-1:0] b_byteen,
    input  logic [DWIDTH-1:0]  b_wdata,
    output logic [DWIDTH-1:0]  b_rdata,
    output logic               b_rvalid
);

    localparam logic [AWIDTH:0]   C_DEPTH = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] C_LAST  = AWIDTH'(DEPTH - 1);

    generate
        if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX ||
            (DWIDTH % 8) != 0 || DEPTH > (2 ** AWIDTH)) begin : g_bad_params
            $error("bram_dp_pipe: illegal RD_LATENCY/DWIDTH/DEPTH");
        end
    endgenerate

    // ---------------- zero-fill sequencer ----------------
    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AWIDTH'(1);
                if (cnt_q == C_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:  ;
            default: state_d = ST_INIT;
        endcase
    end

    logic run, init;
    assign run       = (state_q == ST_RUN);
    assign init      = ~run;
    assign init_busy = init;

    // ---------------- per-port request views ----------------
    logic [AWIDTH-1:0]  addr     [2];
    logic               rd       [2];
    logic               wr       [2];
    logic [BEWIDTH-1:0] be_in    [2];
    logic [DWIDTH-1:0]  wdata    [2];
    logic               in_range [2];
    logic               uwe      [2];  // accepted user write
    logic [BEWIDTH-1:0] eff_be   [2];  // byte enables after collision masking
    logic [DWIDTH-1:0]  rdata_p  [2];
    logic               rvalid_p [2];

    assign addr[0]  = a_addr;   assign addr[1]  = b_addr;
    assign rd[0]    = a_rd;     assign rd[1]    = b_rd;
    assign wr[0]    = a_wr;     assign wr[1]    = b_wr;
    assign be_in[0] = a_byteen; assign be_in[1] = b_byteen;
    assign wdata[0] = a_wdata;  assign wdata[1] = b_wdata;

    assign a_rdata  = rdata_p[0];  assign a_rvalid = rvalid_p[0];
    assign b_rdata  = rdata_p[1];  assign b_rvalid = rvalid_p[1];

    for (genvar p = 0; p < 2; p++) begin : g_req
        assign in_range[p] = ({1'b0, addr[p]} < C_DEPTH);
        assign uwe[p]      = run & ~reset & wr[p] & in_range[p];
    end

    logic same_addr;
    assign same_addr = uwe[0] & uwe[1] & (addr[0] == addr[1]);

    // Port A's physical write path is shared with the zero-fill walker.
    logic              a_we;
    logic [AWIDTH-1:0] a_waddr;
    logic [DWIDTH-1:0] a_wd;
    assign a_we      = (init & ~reset) | uwe[0];
    assign a_waddr   = init ? cnt_q : addr[0];
    assign a_wd      = init ? '0 : wdata[0];
    assign eff_be[0] = init ? '1 : be_in[0];

    for (genvar i = 0; i < BEWIDTH; i++) begin : g_be_mask
        assign eff_be[1][i] = masked_b_be(be_in[0][i], be_in[1][i], same_addr);
    end

    // ---------------- storage ----------------
    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BEWIDTH; i++) begin
            if (uwe[1] && eff_be[1][i]) mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
            if (a_we && eff_be[0][i])   mem[a_waddr][8*i +: 8] <= a_wd[8*i +: 8];
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              acc;
        logic              rv_q;
        logic [DWIDTH-1:0] ram_q;
        logic [DWIDTH-1:0] s1_data;

        assign acc = run & rd[p];

        // Stage 1: RAM output register; nonblocking update gives old data
        // on any same-cycle write.
        always_ff @(posedge clk) begin
            if (reset) begin
                rv_q  <= 1'b0;
                ram_q <= '0;
            end else begin
                rv_q <= acc;
                if (acc) ram_q <= in_range[p] ? mem[addr[p]] : '0;
            end
        end

`ifdef BRAM_DP_RDW_FWD_EN
        logic [BEWIDTH-1:0] fwd_be_d, fwd_be_q;
        logic [DWIDTH-1:0]  fwd_data_d, fwd_data_q;

        // Bytes being written this cycle at the read address; A already
        // owns collided lanes because eff_be[1] is masked.
        always_comb begin
            fwd_be_d   = '0;
            fwd_data_d = '0;
            for (int i = 0; i < BEWIDTH; i++) begin
                if (uwe[0] && addr[0] == addr[p] && eff_be[0][i]) begin
                    fwd_be_d[i]          = 1'b1;
                    fwd_data_d[8*i +: 8] = wdata[0][8*i +: 8];
                end else if (uwe[1] && addr[1] == addr[p] && eff_be[1][i]) begin
                    fwd_be_d[i]          = 1'b1;
                    fwd_data_d[8*i +: 8] = wdata[1][8*i +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                fwd_be_q   <= '0;
                fwd_data_q <= '0;
            end else if (acc) begin
                fwd_be_q   <= fwd_be_d;
                fwd_data_q <= fwd_data_d;
            end
        end

        always_comb begin
            s1_data = ram_q;
            for (int i = 0; i < BEWIDTH; i++) begin
                if (fwd_be_q[i]) s1_data[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
`else
        assign s1_data = ram_q;
`endif

        bram_rd_pipe #(
            .DWIDTH (DWIDTH),
            .STAGES (RD_LATENCY - 1)
        ) u_rd_pipe (
            .clk     (clk),
            .reset   (reset),
            .valid_i (rv_q),
            .data_i  (s1_data),
            .valid_o (rvalid_p[p]),
            .data_o  (rdata_p[p])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_dp_pipe
//  Description : Self-checking bench for bram_dp_pipe. Three instances with
//                RD_LATENCY 1, 2 and 4 share one stimulus stream; a
//                word-level reference memory plus a per-cycle read history
//                predicts busy, rvalid and rdata for every instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dp_pipe;

    localparam int DW = 512;
    localparam int BW = DW / 8;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_rd, a_wr, b_rd, b_wr;
    logic [BW-1:0] a_byteen, b_byteen;
    logic [DW-1:0] a_wdata, b_wdata;

    logic          busy_w     [3];
    logic [DW-1:0] a_rdata_w  [3];
    logic [DW-1:0] b_rdata_w  [3];
    logic          a_rvalid_w [3];
    logic          b_rvalid_w [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bram_dp_pipe #(
            .DWIDTH     (DW),
            .AWIDTH     (AW),
            .DEPTH      (DEPTH),
            .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .init_busy (busy_w[g]),
            .a_addr    (a_addr),
            .a_rd      (a_rd),
            .a_wr      (a_wr),
            .a_byteen  (a_byteen),
            .a_wdata   (a_wdata),
            .a_rdata   (a_rdata_w[g]),
            .a_rvalid  (a_rvalid_w[g]),
            .b_addr    (b_addr),
            .b_rd      (b_rd),
            .b_wr      (b_wr),
            .b_byteen  (b_byteen),
            .b_wdata   (b_wdata),
            .b_rdata   (b_rdata_w[g]),
            .b_rvalid  (b_rvalid_w[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    int            busy_left = DEPTH;
    logic          hv [2][8];          // read accepted at cycle index
    logic [DW-1:0] hd [2][8];          // word that read must return
    logic [DW-1:0] last_d [3][2];      // rdata each instance should hold
    int            cyc = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic logic [DW-1:0] read_value(input logic [AW-1:0] r);
        logic [DW-1:0] v;
        v = ref_mem[r];
`ifdef BRAM_DP_RDW_FWD_EN
        for (int i = 0; i < BW; i++) begin
            if (a_wr && a_addr == r && a_byteen[i])      v[8*i +: 8] = a_wdata[8*i +: 8];
            else if (b_wr && b_addr == r && b_byteen[i]) v[8*i +: 8] = b_wdata[8*i +: 8];
        end
`endif
        return v;
    endfunction

    task automatic model_apply();
        int c8;
        c8 = cyc % 8;
        if (reset) begin
            busy_left = DEPTH;
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 4; k++) hv[p][(cyc + 8 - k) % 8] = 1'b0;
            for (int g = 0; g < 3; g++)
                for (int p = 0; p < 2; p++) last_d[g][p] = '0;
        end else if (busy_left > 0) begin
            ref_mem[DEPTH - busy_left] = '0;
            busy_left--;
            hv[0][c8] = 1'b0;
            hv[1][c8] = 1'b0;
        end else begin
            hv[0][c8] = a_rd;  hd[0][c8] = read_value(a_addr);
            hv[1][c8] = b_rd;  hd[1][c8] = read_value(b_addr);
            // B first, then A over it: A owns every byte both ports write.
            for (int i = 0; i < BW; i++) begin
                if (b_wr && b_byteen[i]) ref_mem[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
                if (a_wr && a_byteen[i]) ref_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
            end
        end
    endtask

    task automatic check_outputs(input int e);
        for (int g = 0; g < 3; g++) begin
            int idx;
            idx = (e - lat_of(g) + 9) % 8;
            check($sformatf("busy_lat%0d", lat_of(g)), busy_w[g], busy_left > 0);
            for (int p = 0; p < 2; p++) begin
                logic v;
                v = hv[p][idx];
                if (v) last_d[g][p] = hd[p][idx];
                check($sformatf("rvalid_lat%0d_p%0d_c%0d", lat_of(g), p, e),
                      (p == 0) ? a_rvalid_w[g] : b_rvalid_w[g], v);
                check($sformatf("rdata_lat%0d_p%0d_c%0d", lat_of(g), p, e),
                      (p == 0) ? a_rdata_w[g] : b_rdata_w[g], last_d[g][p]);
            end
        end
    endtask

    task automatic cycle();
        model_apply();
        @(posedge clk);
        #1;
        check_outputs(cyc);
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        a_byteen = '0; b_byteen = '0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    task automatic rand_req(input int base, input int span, input bit force_rd);
        a_rd     = force_rd | 1'($urandom_range(0, 1));
        b_rd     = force_rd | 1'($urandom_range(0, 1));
        a_wr     = 1'($urandom_range(0, 1));
        b_wr     = 1'($urandom_range(0, 1));
        a_addr   = AW'(base + $urandom_range(0, span - 1));
        b_addr   = AW'(base + $urandom_range(0, span - 1));
        a_byteen = {$urandom, $urandom};
        b_byteen = {$urandom, $urandom};
        a_wdata  = rand_word();
        b_wdata  = rand_word();
    endtask

    // Read one word on port A and compare what the latency-2 instance returns.
    task automatic read_a_expect(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        idle();
        a_rd = 1'b1; a_addr = addr;
        cycle();
        idle();
        cycle();
        check({tag, "_rvalid"}, a_rvalid_w[1], 1'b1);
        check({tag, "_rdata"}, a_rdata_w[1], exp);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (busy_w[1] && n < 600) begin
            rand_req(20, 4, 1'b0);
            cycle();
            n++;
        end
        idle();
        check(tag, n, DEPTH);
    endtask

    initial begin
        logic [DW-1:0] exp_w;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 8; k++) begin hv[p][k] = 1'b0; hd[p][k] = '0; end
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        idle();

        // Reset, then the zero-fill must take exactly DEPTH cycles.
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        wait_init("init_len_first");

        read_a_expect("rd_1ff", 9'h1FF, '0);

        // Sequential partial overwrite at address 5.
        idle(); a_wr = 1'b1; a_addr = 9'd5; a_byteen = '1; a_wdata = {BW{8'hAA}};
        cycle();
        idle(); b_wr = 1'b1; b_addr = 9'd5; b_byteen = BW'(1); b_wdata = {BW{8'h55}};
        cycle();
        read_a_expect("addr5", 9'd5, {{(BW-1){8'hAA}}, 8'h55});

        // Same-cycle collision at address 9 over a known background.
        idle(); a_wr = 1'b1; a_addr = 9'd9; a_byteen = '1; a_wdata = {BW{8'h33}};
        cycle();
        idle();
        a_wr = 1'b1; a_addr = 9'd9; a_byteen = BW'(8'h0F); a_wdata = {BW{8'h11}};
        b_wr = 1'b1; b_addr = 9'd9; b_byteen = BW'(8'hFF); b_wdata = {BW{8'h22}};
        cycle();
        read_a_expect("collide9", 9'd9, {{(BW-8){8'h33}}, {4{8'h22}}, {4{8'h11}}});

        // Read port A while port B writes the same address.
        idle(); a_wr = 1'b1; a_addr = 9'd3; a_byteen = '1; a_wdata = {BW{8'h77}};
        cycle();
        idle();
        a_rd = 1'b1; a_addr = 9'd3;
        b_wr = 1'b1; b_addr = 9'd3; b_byteen = '1; b_wdata = DW'(16'hDEAD);
        cycle();
        idle();
        cycle();
`ifdef BRAM_DP_RDW_FWD_EN
        exp_w = DW'(16'hDEAD);
`else
        exp_w = {BW{8'h77}};
`endif
        check("rdw_addr3", a_rdata_w[1], exp_w);

        // Reads on both ports every cycle with random colliding writes.
        for (int i = 0; i < 100; i++) begin rand_req(0, 8, 1'b1); cycle(); end
        for (int i = 0; i < 200; i++) begin rand_req(0, 8, 1'b0); cycle(); end
        idle();
        repeat (5) cycle();

        // Populate 20..23, then reset with reads in flight.
        for (int k = 0; k < 4; k++) begin
            idle(); a_wr = 1'b1; a_addr = AW'(20 + k); a_byteen = '1; a_wdata = rand_word();
            cycle();
        end
        idle(); a_rd = 1'b1; b_rd = 1'b1; a_addr = 9'd20; b_addr = 9'd21;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin rand_req(20, 4, 1'b0); cycle(); end
        rand_req(20, 4, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_init("init_len_restart");
        for (int k = 0; k < 4; k++) read_a_expect($sformatf("zeroed_%0d", 20 + k), AW'(20 + k), '0);

        repeat (4) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
